vote_session_ctrl: RTL and testbench
====================================

# vote_session_ctrl

Ballot-sequencing controller sitting between the four raw candidate buttons and the `voting_machine` vote-count/LED datapath. It does four things:
- Authorises exactly one ballot per officer `arm` pulse.
- Qualifies a press only when a single button is held stable for `HOLD_CYCLES`.
- Rejects multi-button presses and forfeits idle ballots on timeout.
- Drives candidate selection for the result-display mode.

The count datapath increments only on `vote_valid`.

## Interface
- `HOLD_CYCLES`, 10: consecutive sampling edges a sole button must be high to qualify a vote (≥2).
- `TIMEOUT_CYCLES`, 1000: cycles an armed ballot may stay unused before forfeit (≥HOLD_CYCLES+2).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `mode`  in  1  0 = voting, 1 = result display; honoured only in IDLE/RESULT.
- `arm`  in  1  officer ballot-authorise; level sampled; acted on only in IDLE.
- `button1`..`button4`  in  1 each  raw candidate buttons (candidate index 0..3).
- `ready`  out  1  high while a ballot is armed (ARMED, DEBOUNCE).
- `vote_valid`  out  1  one-cycle commit pulse to counters.
- `vote_id`  out  2  candidate index; valid when `vote_valid`=1, else 0.
- `conflict`  out  1  one-cycle pulse: ≥2 buttons high while armed.
- `timeout`  out  1  one-cycle pulse: armed ballot forfeited.
- `result_en`  out  1  high in RESULT; datapath shows the count for `result_sel` on `led`.
- `result_sel`  out  2  candidate selected for display; held until changed or reset.

## Operation
- **States:** IDLE, ARMED, DEBOUNCE, COMMIT, WAIT_REL, RESULT.
- **Reset** (any state, mid-ballot included) → IDLE:
  - Hold and timeout counters cleared; latched candidate = 0.
  - All outputs 0, `result_sel` = 0.
  - An in-progress ballot is lost and no pulse is emitted.
- **IDLE:** `mode`=1 → RESULT (priority over `arm`); else `arm`=1 → ARMED. Buttons ignored.
- **ARMED:**
  - Exactly one button high → DEBOUNCE; latch its index; hold count = 1.
  - ≥2 high → `conflict` pulse; stay ARMED.
  - None high → stay.
  - `mode` and `arm` ignored.
- **DEBOUNCE:**
  - Latched button still the sole high button → hold count +1.
  - On the edge where the count would reach `HOLD_CYCLES` → COMMIT.
  - Release or a different sole button → ARMED, hold count cleared.
  - ≥2 high → `conflict` pulse, then ARMED.
- **COMMIT** (one cycle): `vote_valid`=1, `vote_id`=latched index → WAIT_REL.
- **WAIT_REL:** `ready`=0; all buttons low → IDLE. `arm` ignored, so a held button can never cast a second vote.
- **Timeout:**
  - Counter cleared on ARMED entry; increments every cycle in ARMED/DEBOUNCE.
  - At count `TIMEOUT_CYCLES`-1 → `timeout` pulse, go to IDLE.
  - If COMMIT and timeout fall on the same edge, COMMIT wins and no `timeout` is issued.
- **RESULT:**
  - `result_en`=1.
  - Any cycle with exactly one button high → `result_sel` = its index next cycle.
  - Multiple buttons high → no change.
  - `mode`=0 → IDLE; `result_sel` retained.
- **Widths:** hold counter `$clog2(HOLD_CYCLES+1)`; timeout counter `$clog2(TIMEOUT_CYCLES+1)`; counters never wrap.

## Timing
- All outputs are registered; reset values are all 0.
- **Vote latency:** if a sole button is sampled high on `HOLD_CYCLES` consecutive edges from ARMED, `vote_valid` is high for the cycle after the `HOLD_CYCLES`-th edge.
- **ARMED entry:** `ready` rises the cycle after the edge that samples `arm`=1 in IDLE.
- **Timeout:** `timeout` is high exactly `TIMEOUT_CYCLES` cycles after ARMED entry if no commit occurs.
- **Conflict:** `conflict` is high the cycle after the offending sample. Repeated conflicting samples give one pulse per cycle.
- **Re-arm:** minimum spacing between two commits is `HOLD_CYCLES`+3 cycles (COMMIT, WAIT_REL, IDLE→ARMED).

## Configuration
- **`VOTE_TIMEOUT_EN`**
  - Defined: timeout counter and forfeit behaviour present as above.
  - Undefined: no timeout counter; ARMED/DEBOUNCE wait indefinitely; `timeout` tied to 0; `TIMEOUT_CYCLES` unused.

## Test plan
All scenarios use `HOLD_CYCLES`=10, `TIMEOUT_CYCLES`=50, 10 ns clock.
1. **Unarmed press:** hold `rst` 10 cycles, then press `button1` for 20 cycles without `arm` → all outputs stay 0; no `vote_valid`.
2. **Normal vote:** `arm` 1 cycle, then `button1` held 20 cycles → a single `vote_valid` with `vote_id`=0, the cycle after the 10th sampling edge. `ready` drops with the pulse. After release, state is IDLE; a second press produces no vote.
3. **Short press then full press:** `arm`, then `button2` held 5 cycles and released → no vote and `ready` stays 1. Then `button2` held 10 cycles → `vote_valid` with `vote_id`=1.
4. **Conflict:** `arm`, then `button2`+`button3` together for 3 cycles → 3 `conflict` pulses, no vote. Release, then `button3` held 10 cycles → `vote_id`=2.
5. **Timeout and mid-ballot reset:**
   - `arm` with no press → `timeout` pulse 50 cycles later, `ready`=0.
   - Re-arm, press `button4` for 5 cycles, assert `rst` 1 cycle → IDLE with no `vote_valid`.
   - Without `VOTE_TIMEOUT_EN`, `ready` stays 1 past 50 cycles.
6. **Result mode:** `mode`=1 from IDLE → `result_en`=1. Pulse `button3` 1 cycle → `result_sel`=2. Set `mode`=0 → `result_en`=0 with `result_sel` still 2.

Source files
------------

// File: rtl/vote_session_ctrl.sv
// Ballot sequencer: one vote per officer arm, debounced sole-button qualification, result-display select.
// Optional `VOTE_TIMEOUT_EN adds forfeiture of ballots left idle for TIMEOUT_CYCLES.
module vote_session_ctrl #(
   parameter int HOLD_CYCLES    = 10,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode,
   input  logic       arm,
   input  logic       button1,
   input  logic       button2,
   input  logic       button3,
   input  logic       button4,
   output logic       ready,
   output logic       vote_valid,
   output logic [1:0] vote_id,
   output logic       conflict,
   output logic       timeout,
   output logic       result_en,
   output logic [1:0] result_sel
);

   localparam int            HW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_DEBOUNCE, S_COMMIT, S_WAIT_REL, S_RESULT
   } state_e;

   state_e        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [1:0]    cand_q, cand_d;
   logic          ready_q, ready_d;
   logic          vote_valid_q, vote_valid_d;
   logic [1:0]    vote_id_q, vote_id_d;
   logic          conflict_q, conflict_d;
   logic          timeout_q, timeout_d;
   logic          result_en_q, result_en_d;
   logic [1:0]    result_sel_q, result_sel_d;

   logic [3:0] btn;
   logic       sole, multi;
   logic [1:0] btn_idx;
   logic       tmo_hit;

   assign btn = {button4, button3, button2, button1};

   always_comb begin
      sole    = 1'b1;
      btn_idx = 2'd0;
      case (btn)
         4'b0001: btn_idx = 2'd0;
         4'b0010: btn_idx = 2'd1;
         4'b0100: btn_idx = 2'd2;
         4'b1000: btn_idx = 2'd3;
         default: sole = 1'b0;
      endcase
      multi = !sole && (btn != 4'b0000);
   end

`ifdef VOTE_TIMEOUT_EN
   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_q, tmo_d;

   assign tmo_hit = ((state_q == S_ARMED) || (state_q == S_DEBOUNCE)) && (tmo_q == TMO_LAST);
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d      = state_q;
      hold_d       = hold_q;
      cand_d       = cand_q;
      result_sel_d = result_sel_q;
      vote_valid_d = 1'b0;
      vote_id_d    = 2'd0;
      conflict_d   = 1'b0;
      timeout_d    = 1'b0;
`ifdef VOTE_TIMEOUT_EN
      tmo_d        = tmo_q;
      if ((state_q == S_ARMED) || (state_q == S_DEBOUNCE)) tmo_d = tmo_q + TW'(1);
`endif

      case (state_q)
         S_IDLE: begin
            hold_d = '0;
            if (mode) begin
               state_d = S_RESULT;
            end else if (arm) begin
               state_d = S_ARMED;
`ifdef VOTE_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end
         end
         S_ARMED: begin
            if (sole) begin
               state_d = S_DEBOUNCE;
               cand_d  = btn_idx;
               hold_d  = HW'(1);
            end else if (multi) begin
               conflict_d = 1'b1;
            end
         end
         S_DEBOUNCE: begin
            if (sole && (btn_idx == cand_q)) begin
               if (hold_q == HOLD_LAST) begin
                  state_d      = S_COMMIT;
                  vote_valid_d = 1'b1;
                  vote_id_d    = cand_q;
                  hold_d       = '0;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end else begin
               state_d    = S_ARMED;
               hold_d     = '0;
               conflict_d = multi;
            end
         end
         S_COMMIT:   state_d = S_WAIT_REL;
         S_WAIT_REL: if (btn == 4'b0000) state_d = S_IDLE;
         S_RESULT: begin
            if (sole) result_sel_d = btn_idx;
            if (!mode) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A commit landing on the forfeit edge keeps the vote.
      if (tmo_hit && (state_d != S_COMMIT)) begin
         state_d    = S_IDLE;
         hold_d     = '0;
         conflict_d = 1'b0;
         timeout_d  = 1'b1;
      end

      ready_d     = (state_d == S_ARMED) || (state_d == S_DEBOUNCE);
      result_en_d = (state_d == S_RESULT);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         hold_q       <= '0;
         cand_q       <= 2'd0;
         ready_q      <= 1'b0;
         vote_valid_q <= 1'b0;
         vote_id_q    <= 2'd0;
         conflict_q   <= 1'b0;
         timeout_q    <= 1'b0;
         result_en_q  <= 1'b0;
         result_sel_q <= 2'd0;
`ifdef VOTE_TIMEOUT_EN
         tmo_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         cand_q       <= cand_d;
         ready_q      <= ready_d;
         vote_valid_q <= vote_valid_d;
         vote_id_q    <= vote_id_d;
         conflict_q   <= conflict_d;
         timeout_q    <= timeout_d;
         result_en_q  <= result_en_d;
         result_sel_q <= result_sel_d;
`ifdef VOTE_TIMEOUT_EN
         tmo_q        <= tmo_d;
`endif
      end
   end

   assign ready      = ready_q;
   assign vote_valid = vote_valid_q;
   assign vote_id    = vote_id_q;
   assign conflict   = conflict_q;
   assign timeout    = timeout_q;
   assign result_en  = result_en_q;
   assign result_sel = result_sel_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl: vector table plus hand sequences for timeout and mid-ballot reset.
module tb_vote_session_ctrl;

   logic       clk = 1'b0;
   logic       rst, mode, arm;
   logic [3:0] btn;
   logic       ready, vote_valid, conflict, timeout, result_en;
   logic [1:0] vote_id, result_sel;
   logic [8:0] obs;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vote_session_ctrl #(.HOLD_CYCLES(10), .TIMEOUT_CYCLES(50)) dut (
      .clk(clk), .rst(rst), .mode(mode), .arm(arm),
      .button1(btn[0]), .button2(btn[1]), .button3(btn[2]), .button4(btn[3]),
      .ready(ready), .vote_valid(vote_valid), .vote_id(vote_id), .conflict(conflict),
      .timeout(timeout), .result_en(result_en), .result_sel(result_sel)
   );

   assign obs = {ready, vote_valid, vote_id, conflict, timeout, result_en, result_sel};

   typedef struct {
      logic       rst;
      logic       mode;
      logic       arm;
      logic [3:0] btn;
      int         reps;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic r, input logic m, input logic a, input logic [3:0] b,
                              input int n, input logic rdy, input logic vv, input logic [1:0] vid,
                              input logic cf, input logic to, input logic re, input logic [1:0] rs);
      vec_t t;
      t.rst  = r;
      t.mode = m;
      t.arm  = a;
      t.btn  = b;
      t.reps = n;
      t.exp  = {rdy, vv, vid, cf, to, re, rs};
      return t;
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int hit;
      int seen;
      rst = 1'b1; mode = 1'b0; arm = 1'b0; btn = 4'b0000;

      // Unarmed press
      tbl.push_back(v(1,0,0,4'b0000,10, 0,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0001,20, 0,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0000, 1, 0,0,0,0,0,0,0));
      // Normal vote, then held/second press gives nothing
      tbl.push_back(v(0,0,1,4'b0000, 1, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0001, 9, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0001, 1, 0,1,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0001,10, 0,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0000, 1, 0,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0001,15, 0,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0000, 1, 0,0,0,0,0,0,0));
      // Short press, switch to another button mid-debounce, then full press
      tbl.push_back(v(0,0,1,4'b0000, 1, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0010, 5, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0000, 3, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0010, 3, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0001, 1, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0001, 8, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0000, 1, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0010, 9, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0010, 1, 0,1,1,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0000, 2, 0,0,0,0,0,0,0));
      // Conflict in ARMED and DEBOUNCE
      tbl.push_back(v(0,0,1,4'b0000, 1, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0110, 3, 1,0,0,1,0,0,0));
      tbl.push_back(v(0,0,0,4'b0000, 1, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0100, 3, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0110, 1, 1,0,0,1,0,0,0));
      tbl.push_back(v(0,0,0,4'b0000, 1, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0100, 9, 1,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0100, 1, 0,1,2,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0000, 2, 0,0,0,0,0,0,0));
      // Result mode, mode priority over arm, mode ignored while armed, reset clears result_sel
      tbl.push_back(v(0,1,1,4'b0000, 1, 0,0,0,0,0,1,0));
      tbl.push_back(v(0,1,0,4'b0100, 1, 0,0,0,0,0,1,2));
      tbl.push_back(v(0,1,0,4'b0000, 2, 0,0,0,0,0,1,2));
      tbl.push_back(v(0,1,0,4'b0011, 1, 0,0,0,0,0,1,2));
      tbl.push_back(v(0,1,0,4'b1000, 1, 0,0,0,0,0,1,3));
      tbl.push_back(v(0,1,0,4'b0100, 1, 0,0,0,0,0,1,2));
      tbl.push_back(v(0,0,0,4'b0000, 2, 0,0,0,0,0,0,2));
      tbl.push_back(v(0,0,1,4'b0000, 1, 1,0,0,0,0,0,2));
      tbl.push_back(v(0,1,0,4'b0000, 2, 1,0,0,0,0,0,2));
      tbl.push_back(v(0,1,0,4'b0100, 2, 1,0,0,0,0,0,2));
      tbl.push_back(v(1,1,0,4'b0100, 1, 0,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,4'b0000, 1, 0,0,0,0,0,0,0));

      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].reps; r++) begin
            rst = tbl[i].rst; mode = tbl[i].mode; arm = tbl[i].arm; btn = tbl[i].btn;
            tick();
            check($sformatf("row%0d_rep%0d", i, r), {7'd0, obs}, {7'd0, tbl[i].exp});
         end
      end

      rst = 1'b0; mode = 1'b0; btn = 4'b0000;
      arm = 1'b1;
      tick();
      check("arm_ready", {15'd0, ready}, 16'd1);
      arm = 1'b0;
`ifdef VOTE_TIMEOUT_EN
      hit = 0;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (timeout) begin
            hit = i;
            break;
         end
      end
      check("timeout_latency", 16'(hit), 16'd50);
      check("timeout_ready_low", {15'd0, ready}, 16'd0);
      tick();
      check("timeout_one_cycle", {15'd0, timeout}, 16'd0);

      // Commit and forfeit on the same edge: the vote wins
      arm = 1'b1;
      tick();
      arm = 1'b0;
      repeat (40) tick();
      btn = 4'b0001;
      repeat (9) tick();
      check("late_press_armed", {14'd0, ready, timeout}, 16'b10);
      tick();
      check("commit_beats_timeout", {13'd0, vote_valid, timeout, ready}, 16'b100);
      btn = 4'b0000;
      tick();
      check("no_late_timeout", {15'd0, timeout}, 16'd0);
      tick();
`else
      seen = 0;
      repeat (60) begin
         tick();
         if (timeout) seen++;
      end
      check("no_timeout_ready", {15'd0, ready}, 16'd1);
      check("no_timeout_pulse", 16'(seen), 16'd0);
`endif

      // Mid-ballot reset loses the ballot silently
      arm = 1'b1;
      tick();
      arm = 1'b0;
      btn = 4'b1000;
      repeat (5) tick();
      check("prereset_debounce", {15'd0, ready}, 16'd1);
      rst = 1'b1;
      tick();
      check("midballot_reset", {7'd0, obs}, 16'd0);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         tick();
         if (vote_valid || ready) seen++;
      end
      check("postreset_idle", 16'(seen), 16'd0);
      btn = 4'b0000;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
